// File: rtl/sort_sched_pkg.sv
// Shared types and default sizing for the sort job scheduler.
//   sched_state_t : scheduler FSM state encoding
//   DEF_NREQ      : default number of requesters
//   DEF_BANK_W    : default ROM bank-select width
//   DEF_TIMEOUT   : default RUN-cycle limit (used only with SORT_SCHED_TIMEOUT_EN)
package sort_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      CLEAR = 3'd4
   } sched_state_t;

   localparam int DEF_NREQ    = 4;
   localparam int DEF_BANK_W  = 2;
   localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/sort_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick for the sort job scheduler.
// Ports:
//   req     [NREQ-1:0]  pending request bits
//   rr_ptr  [IDX_W-1:0] highest-priority index for this pick
//   winner  [IDX_W-1:0] first set req bit at or after rr_ptr, wrapping
//   any_req             at least one request pending
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any_req
);

   logic [IDX_W-1:0] idx;

   // Walk from the farthest offset down to offset 0 so the candidate
   // closest to rr_ptr is the last one written and therefore wins.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = IDX_W'((int'(rr_ptr) + i) % NREQ);
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/sort_job_scheduler.sv
// Round-robin scheduler sharing one heap-sort engine between NREQ requesters.
// Build option: define SORT_SCHED_TIMEOUT_EN to add a RUN-cycle counter that
// aborts a job after TIMEOUT cycles without eng_done and pulses err.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req      [NREQ]       level request per requester, held until ack/err
//   req_bank [NREQ*BANK_W] per-requester bank, sampled at grant
//   ack      [NREQ]       one-cycle success pulse to the owner
//   err      [NREQ]       one-cycle abort pulse to the owner
//   eng_start             one-cycle engine start
//   eng_bank [BANK_W]     bank of current job
//   eng_rst               engine reset, active-high
//   eng_done              engine done level
//   busy                  high outside IDLE
//   owner    [log2 NREQ]  current job owner
//
// state | meaning
// IDLE  | engine held in reset, waiting for any request
// GRANT | owner and bank latched, engine released from reset
// START | eng_start pulse, run counter cleared
// RUN   | waiting for eng_done (or timeout when enabled)
// CLEAR | ack/err pulse to owner, engine back into reset, rr_ptr advanced
module sort_job_scheduler
   import sort_sched_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int BANK_W  = DEF_BANK_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   localparam int OWN_W  = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*BANK_W-1:0] req_bank,
   output logic [NREQ-1:0]        ack,
   output logic [NREQ-1:0]        err,
   output logic                   eng_start,
   output logic [BANK_W-1:0]      eng_bank,
   output logic                   eng_rst,
   input  logic                   eng_done,
   output logic                   busy,
   output logic [OWN_W-1:0]       owner
);

   sched_state_t      state_q, state_d;
   logic              abort_d;
   logic              timeout_hit;
   logic [OWN_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [OWN_W-1:0]  winner;
   logic              any_req;

   logic [NREQ-1:0]   ack_d, err_d;
   logic              eng_start_d, eng_rst_d, busy_d;
   logic [BANK_W-1:0] eng_bank_d;
   logic [OWN_W-1:0]  owner_d;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (OWN_W)
   ) u_arb (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

`ifdef SORT_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] run_cnt_q;

   // Counter reads k in the k-th RUN cycle after entry (0-based), so the
   // abort decision at count TIMEOUT lands err TIMEOUT+1 cycles after entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt_q <= '0;
      end else if (state_q == START) begin
         run_cnt_q <= '0;
      end else if (state_q == RUN) begin
         run_cnt_q <= run_cnt_q + 1'b1;
      end
   end

   assign timeout_hit = (run_cnt_q == CNT_W'(TIMEOUT));
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      abort_d = 1'b0;
      case (state_q)
         IDLE:  if (any_req) state_d = GRANT;
         GRANT: state_d = START;
         START: state_d = RUN;
         RUN: begin
            if (eng_done) begin
               state_d = CLEAR;
            end else if (timeout_hit) begin
               state_d = CLEAR;
               abort_d = 1'b1;
            end
         end
         CLEAR: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output values are computed from the upcoming state and registered, so
   // each output is a flop whose timing matches the state it belongs to.
   always_comb begin
      ack_d       = '0;
      err_d       = '0;
      eng_start_d = (state_d == START);
      eng_rst_d   = (state_d == IDLE) || (state_d == CLEAR);
      busy_d      = (state_d != IDLE);
      eng_bank_d  = eng_bank;
      owner_d     = owner;
      rr_ptr_d    = rr_ptr_q;
      if ((state_q == IDLE) && (state_d == GRANT)) begin
         owner_d    = winner;
         eng_bank_d = req_bank[winner*BANK_W +: BANK_W];
      end
      if (state_d == CLEAR) begin
         if (abort_d) begin
            err_d[owner] = 1'b1;
         end else begin
            ack_d[owner] = 1'b1;
         end
      end
      if (state_q == CLEAR) begin
         rr_ptr_d = (owner == OWN_W'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack       <= '0;
         err       <= '0;
         eng_start <= 1'b0;
         eng_bank  <= '0;
         eng_rst   <= 1'b1;
         busy      <= 1'b0;
         owner     <= '0;
         rr_ptr_q  <= '0;
      end else begin
         ack       <= ack_d;
         err       <= err_d;
         eng_start <= eng_start_d;
         eng_bank  <= eng_bank_d;
         eng_rst   <= eng_rst_d;
         busy      <= busy_d;
         owner     <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Self-checking bench for sort_job_scheduler (NREQ=4, BANK_W=2, TIMEOUT=15).
// Job table plus hand sequences; completions go through an expected-result queue.
module tb_sort_job_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [7:0] req_bank;
   logic [3:0] ack, err;
   logic       eng_start;
   logic [1:0] eng_bank;
   logic       eng_rst;
   logic       eng_done;
   logic       busy;
   logic [1:0] owner;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   logic [7:0] exp_q[$];

   sort_job_scheduler #(.NREQ(4), .BANK_W(2), .TIMEOUT(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_bank  (req_bank),
      .ack       (ack),
      .err       (err),
      .eng_start (eng_start),
      .eng_bank  (eng_bank),
      .eng_rst   (eng_rst),
      .eng_done  (eng_done),
      .busy      (busy),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every ack/err pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (!reset && ((ack != 4'b0) || (err != 4'b0))) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", {24'b0, ack, err}, 32'h0);
         end else begin
            check("sb_done", {24'b0, ack, err}, {24'b0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_vals(input string name);
      check({name, "_ack"},   ack, 0);
      check({name, "_err"},   err, 0);
      check({name, "_start"}, eng_start, 0);
      check({name, "_bank"},  eng_bank, 0);
      check({name, "_rst"},   eng_rst, 1);
      check({name, "_busy"},  busy, 0);
      check({name, "_owner"}, owner, 0);
   endtask

   // Waits for eng_start from an IDLE-cycle negedge; returns negedges elapsed.
   task automatic wait_start(input string name, output int n, output bit seen);
      n = 0;
      seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) check({name, "_grant_rst"}, eng_rst, 0);
         if (eng_start) seen = 1;
      end
      check({name, "_start_lat"}, n, 2);
   endtask

   task automatic run_job(input string name, input int exp_own, input int exp_bank,
                          input int delay, input bit spurious);
      int n;
      bit seen;
      wait_start(name, n, seen);
      if (!seen) return;
      if (spurious) eng_done = 1'b0;
      check({name, "_owner"}, owner, exp_own);
      check({name, "_bank"}, eng_bank, exp_bank);
      repeat (delay + 1) @(negedge clk);
      check({name, "_busy_run"}, busy, 1);
      exp_q.push_back({4'(1 << exp_own), 4'b0});
      eng_done = 1'b1;
      @(negedge clk);
      check({name, "_ack"}, ack, 1 << exp_own);
      check({name, "_ack_rst"}, eng_rst, 1);
      eng_done = 1'b0;
      @(negedge clk);
      check({name, "_idle_rst"}, eng_rst, 1);
      check({name, "_idle_ack"}, ack, 0);
   endtask

   typedef struct {
      logic [3:0] req;
      logic [7:0] bank;
      int         delay;
      int         exp_own;
      int         exp_bank;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n;
      bit seen;
      int err_seen;

      vecs[0] = '{req: 4'b0001, bank: 8'h02, delay: 300, exp_own: 0, exp_bank: 2};
      vecs[1] = '{req: 4'b1111, bank: 8'hE4, delay: 5,   exp_own: 1, exp_bank: 1};
      vecs[2] = '{req: 4'b0001, bank: 8'h03, delay: 1,   exp_own: 0, exp_bank: 3};
      vecs[3] = '{req: 4'b1001, bank: 8'h42, delay: 0,   exp_own: 3, exp_bank: 1};
      vecs[4] = '{req: 4'b1000, bank: 8'h80, delay: 2,   exp_own: 3, exp_bank: 2};
      vecs[5] = '{req: 4'b0110, bank: 8'h1C, delay: 4,   exp_own: 1, exp_bank: 3};

      reset = 1'b1;
      req = 4'b0;
      req_bank = 8'h0;
      eng_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         req = vecs[v].req;
         req_bank = vecs[v].bank;
         run_job($sformatf("vec%0d", v), vecs[v].exp_own, vecs[v].exp_bank, vecs[v].delay, 1'b0);
         req = 4'b0;
      end

      // Contention from reset: 1 then 3.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req = 4'b1010;
      req_bank = 8'h84;
      run_job("cont_a", 1, 1, 3, 1'b0);
      run_job("cont_b", 3, 2, 3, 1'b0);
      req = 4'b0;

      // Fairness with both held: 0,1,0,1.
      req = 4'b0011;
      req_bank = 8'h09;
      run_job("fair_0", 0, 1, 1, 1'b0);
      run_job("fair_1", 1, 2, 1, 1'b0);
      run_job("fair_2", 0, 1, 1, 1'b0);
      run_job("fair_3", 1, 2, 1, 1'b0);
      req = 4'b0;

      // Spurious done while in IDLE/GRANT/START must not complete the job.
      req = 4'b0100;
      req_bank = 8'h30;
      eng_done = 1'b1;
      run_job("spur", 2, 3, 3, 1'b1);
      req = 4'b0;

      // Reset mid-RUN: job dropped silently, re-granted from rr_ptr=0.
      req = 4'b1001;
      req_bank = 8'h81;
      wait_start("rstrun", n, seen);
      check("rstrun_owner", owner, 3);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("rstrun_rv");
      reset = 1'b0;
      run_job("rstrun_regrant", 0, 1, 2, 1'b0);
      req = 4'b0;

      // Timeout path (owner 2 after rr_ptr advanced to 1).
      req = 4'b0100;
      req_bank = 8'h20;
      wait_start("tmo", n, seen);
      check("tmo_owner", owner, 2);
      check("tmo_bank", eng_bank, 2);
`ifdef SORT_SCHED_TIMEOUT_EN
      exp_q.push_back({4'b0000, 4'b0100});
      n = 0;
      while (err == 4'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tmo_err_lat", n, 17);
      check("tmo_err", err, 4'b0100);
      check("tmo_noack", ack, 0);
      check("tmo_rst", eng_rst, 1);
      req = 4'b0;
      @(negedge clk);
      check("tmo_idle", busy, 0);
`else
      err_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (err != 4'b0) err_seen = 1;
      end
      check("noto_err", err_seen, 0);
      check("noto_busy", busy, 1);
      exp_q.push_back({4'b0100, 4'b0000});
      eng_done = 1'b1;
      @(negedge clk);
      check("noto_ack", ack, 4'b0100);
      eng_done = 1'b0;
      req = 4'b0;
      @(negedge clk);
      check("noto_idle", busy, 0);
`endif

      repeat (3) @(negedge clk);
      check("sb_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/sort_job_scheduler.md
# sort_job_scheduler

Shares one heap-sort engine (16 × 8-bit ROM → RAM sorter) between several requesters. Arbitrates pending sort jobs round-robin, drives the engine's start, bank-select and reset controls, and returns a per-requester completion pulse. It sits between the job-issuing blocks and the sort engine, which it owns exclusively.

## Interface
- NREQ, 4, number of requesters (2..8)
- BANK_W, 2, width of ROM bank select handed to the engine
- TIMEOUT, 1023, max RUN cycles before abort (used only with SORT_SCHED_TIMEOUT_EN)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  NREQ  level request per requester; hold until ack/err
- req_bank  in  NREQ*BANK_W  per-requester bank, slice i = [i*BANK_W +: BANK_W]; sampled at grant
- ack  out  NREQ  one-cycle pulse to owner on successful completion
- err  out  NREQ  one-cycle pulse to owner on timeout abort
- eng_start  out  1  one-cycle start pulse to engine
- eng_bank  out  BANK_W  bank for current job, held GRANT..CLEAR
- eng_rst  out  1  engine reset, active-high
- eng_done  in  1  engine done level (stays high until engine reset)
- busy  out  1  high in every state except IDLE
- owner  out  $clog2(NREQ)  index of current job owner

## Operation
- States: IDLE, GRANT, START, RUN, CLEAR.
- IDLE: eng_rst=1. If any req bit set → GRANT; winner = first set bit at or after rr_ptr (wrapping modulo NREQ). Latch owner, eng_bank ← req_bank[winner].
- GRANT: eng_rst←0 (engine released from reset) → START.
- START: eng_start pulses 1 cycle; run counter cleared → RUN.
- RUN: wait for eng_done=1 → CLEAR with success. With macro, counter increments each RUN cycle; counter==TIMEOUT without eng_done → CLEAR with abort.
- CLEAR: pulse ack[owner] (success) or err[owner] (abort); eng_rst←1; rr_ptr ← owner+1 mod NREQ → IDLE.
- eng_done ignored outside RUN.
- req deasserted mid-job: job completes, ack/err still issued.
- req still high after ack: treated as new request, competes at lowest priority under updated rr_ptr.
- Exactly one of ack/err bits high at a time, only in CLEAR.

## Timing
- Reset values: ack=0, err=0, eng_start=0, eng_bank=0, eng_rst=1, busy=0, owner=0, rr_ptr=0, state IDLE.
- Reset mid-operation: next edge returns all of the above; engine held in reset; no ack/err for aborted job.
- req sampled in IDLE cycle T → GRANT T+1 → eng_start high T+2 → RUN from T+3.
- eng_done first seen high in RUN at cycle D → ack at D+1 → IDLE at D+2; new job granted D+2 earliest, start D+4.
- Abort: err asserted TIMEOUT+1 cycles after RUN entry.
- All outputs registered; no combinational path req→ack or eng_done→ack.

## Configuration
- SORT_SCHED_TIMEOUT_EN defined: run counter of $clog2(TIMEOUT+1) bits present; abort path active; err driven.
- Undefined: no counter; RUN waits indefinitely for eng_done; err tied to 0; TIMEOUT ignored.

## Structure
- Package sort_sched_pkg: state enum (IDLE, GRANT, START, RUN, CLEAR), default NREQ/BANK_W/TIMEOUT constants.
- Sub-module rr_arbiter: combinational round-robin pick, inputs req and rr_ptr, outputs winner index and any_req; the FSM holds rr_ptr.

## Test plan
- Single job: req=4'b0001, req_bank[1:0]=2 → eng_bank=2, eng_start 2 cycles later; drive eng_done after 300 cycles → ack=4'b0001 one cycle, eng_rst=1 next.
- Contention: req=4'b1010 held from reset → owners 1 then 3; ack order 4'b0010, 4'b1000.
- Fairness: req=4'b0011 held continuously → owner sequence 0,1,0,1; neither requester starved.
- Timeout (macro on, TIMEOUT=15): never drive eng_done → err[owner] pulse 16 cycles after RUN entry, no ack, eng_rst=1.
- Reset mid-RUN: assert reset 1 cycle → all outputs at reset values next edge, no ack/err, pending req re-granted from rr_ptr=0.
- Spurious done: eng_done high during GRANT/START → ignored; completion only on RUN-state done.
